// File: rtl/accum4.sv
// accum4: accumulates COUNT 4-bit sums per frame and hands the 8-bit total downstream
module accum4 #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_sum,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_total,
  output logic       out_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state, state_n;
  logic [7:0] total, total_n;
  logic [4:0] cnt, cnt_n;
  logic ovf, ovf_n;
  logic [8:0] sum;
  logic take, give;
  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == EMIT);
  assign out_total = total;
  assign out_ovf   = ovf;
  assign busy      = out_valid || (cnt != 5'd0);
  always_comb begin
    take    = in_valid && in_ready;
    give    = out_valid && out_ready;
    sum     = {1'b0, total} + {5'd0, in_sum};
    state_n = give ? ACCUM : (take && (cnt + 5'd1 == 5'(COUNT))) ? EMIT : state;
    total_n = give ? 8'd0 : take ? sum[7:0] : total;
    cnt_n   = give ? 5'd0 : take ? cnt + 5'd1 : cnt;
    ovf_n   = give ? 1'b0 : ovf || (take && sum[8]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      total <= 8'd0;
      cnt   <= 5'd0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      total <= total_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end
endmodule

// File: tb/tb_accum4.sv
// tb_accum4: five accum4 instances of different COUNT checked cycle by cycle against a frame-sum model
module tb_accum4;
  localparam int N = 5;
  localparam int CNTS [N] = '{4, 20, 3, 2, 1};
  logic clk, rst, in_valid, out_ready;
  logic [3:0] in_sum;
  logic in_ready [N];
  logic [7:0] out_total [N];
  logic out_ovf [N];
  logic out_valid [N];
  logic busy [N];
  int checks, failures;
  int tot [N];
  int n [N];
  bit pend [N];
  for (genvar g = 0; g < N; g++) begin : gen_dut
    accum4 #(.COUNT(CNTS[g])) dut (
      .clk(clk),
      .rst(rst),
      .in_sum(in_sum),
      .in_valid(in_valid),
      .in_ready(in_ready[g]),
      .out_total(out_total[g]),
      .out_ovf(out_ovf[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .busy(busy[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [8:0] obs, input int exp);
    checks++;
    assert (obs === 9'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic r, input logic v, input logic [3:0] s, input logic o);
    rst = r;
    in_valid = v;
    in_sum = s;
    out_ready = o;
    #4;
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d_in_ready", i), {8'd0, in_ready[i]}, int'(!r && !pend[i]));
      check($sformatf("d%0d_out_valid", i), {8'd0, out_valid[i]}, int'(pend[i]));
      check($sformatf("d%0d_out_total", i), {1'b0, out_total[i]}, tot[i] % 256);
      check($sformatf("d%0d_out_ovf", i), {8'd0, out_ovf[i]}, int'(tot[i] > 255));
      check($sformatf("d%0d_busy", i), {8'd0, busy[i]}, int'(pend[i] || n[i] != 0));
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        tot[i] = 0;
        n[i] = 0;
        pend[i] = 0;
      end else if (pend[i]) begin
        if (o) begin
          tot[i] = 0;
          n[i] = 0;
          pend[i] = 0;
        end
      end else if (v) begin
        tot[i] += int'(s);
        n[i]++;
        if (n[i] == CNTS[i]) pend[i] = 1;
      end
    end
    #1;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sum = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      tot[i] = 0;
      n[i] = 0;
      pend[i] = 0;
    end
    cycle(1, 1, 4'd5, 1);
    cycle(0, 0, 4'd0, 1);
    check("reset_total", {1'b0, out_total[0]}, 0);
    check("reset_valid", {8'd0, out_valid[0]}, 0);
    cycle(0, 1, 4'd1, 1);
    cycle(0, 1, 4'd2, 1);
    cycle(0, 1, 4'd3, 1);
    check("basic_not_yet", {8'd0, out_valid[0]}, 0);
    cycle(0, 1, 4'd4, 1);
    check("basic_valid", {8'd0, out_valid[0]}, 1);
    check("basic_total", {1'b0, out_total[0]}, 10);
    check("basic_ovf", {8'd0, out_ovf[0]}, 0);
    cycle(0, 0, 4'd0, 1);
    check("basic_pulse", {8'd0, out_valid[0]}, 0);
    cycle(1, 0, 4'd0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 4'd5, 0);
    for (int k = 0; k < 6; k++) cycle(0, 1, 4'd7, 0);
    check("bp_total", {1'b0, out_total[0]}, 20);
    check("bp_valid", {8'd0, out_valid[0]}, 1);
    check("bp_ready", {8'd0, in_ready[0]}, 0);
    cycle(0, 1, 4'd7, 1);
    check("bp_cleared", {1'b0, out_total[0]}, 0);
    cycle(0, 1, 4'd2, 1);
    check("bp_next_frame", {1'b0, out_total[0]}, 2);
    cycle(1, 0, 4'd0, 1);
    for (int k = 0; k < 20; k++) cycle(0, 1, 4'd15, 1);
    check("ovf_total", {1'b0, out_total[1]}, 44);
    check("ovf_flag", {8'd0, out_ovf[1]}, 1);
    check("ovf_valid", {8'd0, out_valid[1]}, 1);
    cycle(0, 0, 4'd0, 1);
    for (int k = 0; k < 20; k++) cycle(0, 1, 4'd1, 1);
    check("ovf2_total", {1'b0, out_total[1]}, 20);
    check("ovf2_flag", {8'd0, out_ovf[1]}, 0);
    cycle(1, 0, 4'd0, 0);
    cycle(0, 1, 4'd2, 0);
    cycle(0, 0, 4'd9, 0);
    cycle(0, 0, 4'd9, 0);
    cycle(0, 1, 4'd3, 0);
    check("bubble_wait", {8'd0, out_valid[2]}, 0);
    cycle(0, 0, 4'd9, 0);
    cycle(0, 1, 4'd4, 0);
    check("bubble_total", {1'b0, out_total[2]}, 9);
    check("bubble_valid", {8'd0, out_valid[2]}, 1);
    cycle(1, 0, 4'd0, 1);
    cycle(0, 1, 4'd9, 1);
    cycle(0, 1, 4'd9, 1);
    cycle(1, 1, 4'd9, 1);
    check("rst_mid_valid", {8'd0, out_valid[0]}, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 4'd1, 1);
    check("rst_mid_total", {1'b0, out_total[0]}, 4);
    check("rst_mid_ovf", {8'd0, out_ovf[0]}, 0);
    cycle(1, 0, 4'd0, 1);
    cycle(0, 1, 4'd3, 1);
    cycle(0, 1, 4'd4, 1);
    check("b2b_first", {1'b0, out_total[3]}, 7);
    cycle(0, 1, 4'd6, 1);
    check("b2b_idle", {1'b0, out_total[3]}, 0);
    cycle(0, 1, 4'd6, 1);
    cycle(0, 1, 4'd1, 1);
    check("b2b_second", {1'b0, out_total[3]}, 7);
    cycle(1, 0, 4'd0, 1);
    cycle(0, 1, 4'd9, 1);
    check("c1_total", {1'b0, out_total[4]}, 9);
    check("c1_ovf", {8'd0, out_ovf[4]}, 0);
    for (int k = 0; k < 600; k++)
      cycle($urandom_range(59) == 0, $urandom_range(3) != 0, 4'($urandom), $urandom_range(9) < 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
